rob_completion_buffer: RTL and testbench



---
 rtl/rob_completion_buffer_pkg.sv | 24 ++
 rtl/rob_completion_buffer_if.sv | 31 +++
 rtl/rob_completion_buffer_ptr.sv | 23 ++
 rtl/rob_completion_buffer.sv | 121 ++++++++++++
 tb/tb_rob_completion_buffer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_completion_buffer_pkg.sv
// Shared ROB types.
//   rob_entry_t  : per-entry state (alloc/done flags plus stored result)
//   rob_commit_t : commit payload handed to the register file
package rob_pkg;

    localparam int ROB_DATA_W = 8;
    localparam int ROB_ID_W   = 8;

    typedef struct packed {
        logic                  alloc;
        logic                  done;
        logic [7:0]            flags;
        logic [7:0]            wbs;
        logic [ROB_DATA_W-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0]   robid;
        logic [7:0]            flags;
        logic [7:0]            wbs;
        logic [ROB_DATA_W-1:0] value;
    } rob_commit_t;

endpackage

// File: rtl/rob_completion_buffer_if.sv
// FU-completion and commit handshakes of the reorder buffer.
//   slave  : ROB side (takes FU results, offers commits)
//   master : environment side (FUs + register file)
interface rob_completion_buffer_if;
    import rob_pkg::*;

    logic                  fu_valid;
    logic [ROB_ID_W-1:0]   fu_robid;
    logic [7:0]            fu_flags;
    logic [7:0]            fu_wbs;
    logic [ROB_DATA_W-1:0] fu_value;
    logic                  fu_accept;

    logic                  commit_valid;
    logic                  commit_ready;
    logic [ROB_ID_W-1:0]   commit_robid;
    logic [7:0]            commit_flags;
    logic [7:0]            commit_wbs;
    logic [ROB_DATA_W-1:0] commit_value;

    modport slave (
        input  fu_valid, fu_robid, fu_flags, fu_wbs, fu_value, commit_ready,
        output fu_accept, commit_valid, commit_robid, commit_flags, commit_wbs, commit_value
    );

    modport master (
        output fu_valid, fu_robid, fu_flags, fu_wbs, fu_value, commit_ready,
        input  fu_accept, commit_valid, commit_robid, commit_flags, commit_wbs, commit_value
    );

endinterface

// File: rtl/rob_completion_buffer_ptr.sv
// Wrapping pointer for the ROB (used as head and tail).
// W is IDX_W+1: the top bit is the wrap bit that tells full from empty.
//   clk, rst_n : clock, async active-low reset
//   inc        : advance by one
//   clr        : synchronous return to zero (flush)
//   ptr        : current pointer value
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/rob_completion_buffer.sv
// In-order retirement buffer: dispatch allocates entries at the tail, FUs
// complete them in any order, and the head retires to the register file
// once done.
//   clk, rst_n  : clock, async active-low reset
//   alloc_req   : dispatch wants one entry; alloc_gnt/alloc_robid answer it
//   full, count : occupancy
//   bus         : FU completion handshake and commit handshake (slave side)
//   flush       : only with ROB_FLUSH_EN defined; discards every entry
module rob_completion_buffer
    import rob_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef ROB_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                alloc_req,
    output logic                alloc_gnt,
    output logic [ROB_ID_W-1:0] alloc_robid,
    output logic                full,
    output logic [IDX_W:0]      count,
    rob_completion_buffer_if.slave bus
);

`ifndef ROB_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    logic [IDX_W:0]   head, tail;
    logic [IDX_W-1:0] head_idx, tail_idx, fu_idx;
    logic             fu_in_range, fire;
    rob_entry_t       ent [DEPTH];
    rob_commit_t      cmt;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign fu_idx   = bus.fu_robid[IDX_W-1:0];

    // full comes from the current count, so a commit in the same cycle
    // does not free a slot for allocation until the next cycle.
    assign full        = (count == (IDX_W+1)'(DEPTH));
    assign alloc_gnt   = alloc_req & ~full & ~flush;
    assign alloc_robid = ROB_ID_W'(tail_idx);

    // Range check first: fu_idx alone would alias out-of-range ids onto
    // live entries.
    assign fu_in_range   = (int'(bus.fu_robid) < DEPTH);
    assign bus.fu_accept = bus.fu_valid & fu_in_range & ent[fu_idx].alloc
                         & ~ent[fu_idx].done & ~flush;

    // Registered state only: a result completing this cycle commits next.
    assign bus.commit_valid = (count != '0) & ent[head_idx].done;
    assign fire             = bus.commit_valid & bus.commit_ready & ~flush;

    always_comb begin
        cmt       = '0;
        cmt.robid = ROB_ID_W'(head_idx);
        cmt.flags = ent[head_idx].flags;
        cmt.wbs   = ent[head_idx].wbs;
        cmt.value = ent[head_idx].value;
    end

    assign bus.commit_robid = cmt.robid;
    assign bus.commit_flags = cmt.flags;
    assign bus.commit_wbs   = cmt.wbs;
    assign bus.commit_value = cmt.value;

    rob_ptr #(.W(IDX_W+1)) u_head (
        .clk(clk), .rst_n(rst_n), .inc(fire), .clr(flush), .ptr(head)
    );

    rob_ptr #(.W(IDX_W+1)) u_tail (
        .clk(clk), .rst_n(rst_n), .inc(alloc_gnt), .clr(flush), .ptr(tail)
    );

    // Allocate, complete and retire never hit the same entry in one cycle:
    // the tail is unallocated, a completing entry is allocated but not done,
    // and the retiring head is done.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ent[g] <= '0;
            end else if (flush) begin
                ent[g].alloc <= 1'b0;
                ent[g].done  <= 1'b0;
            end else begin
                if (alloc_gnt && tail_idx == IDX_W'(g)) begin
                    ent[g].alloc <= 1'b1;
                    ent[g].done  <= 1'b0;
                end
                if (bus.fu_accept && fu_idx == IDX_W'(g)) begin
                    ent[g].done  <= 1'b1;
                    ent[g].flags <= bus.fu_flags;
                    ent[g].wbs   <= bus.fu_wbs;
                    ent[g].value <= bus.fu_value;
                end
                if (fire && head_idx == IDX_W'(g)) begin
                    ent[g].alloc <= 1'b0;
                    ent[g].done  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     count <= '0;
        else if (flush) count <= '0;
        else begin
            case ({alloc_gnt, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_completion_buffer.sv
// Self-checking bench for rob_completion_buffer (DEPTH=16).
// Program order of allocations is queued; completions record the expected
// payload per robid; a monitor pops and compares on every commit fire.
module tb_rob_completion_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       flush = 1'b0;
    logic       alloc_gnt, full;
    logic [7:0] alloc_robid;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    int tb_tail = 0;
    logic [7:0] alloc_q [$];
    logic [7:0] exp_val [256];
    logic [7:0] exp_wbs [256];
    logic [7:0] exp_flg [256];

    rob_completion_buffer_if bus ();

    rob_completion_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_req(alloc_req),
        .alloc_gnt(alloc_gnt),
        .alloc_robid(alloc_robid),
        .full(full),
        .count(count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Commit scoreboard: fire is decided by now and lands on the next edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.commit_valid && bus.commit_ready && !flush) begin
                checks++;
                if (alloc_q.size() == 0) begin
                    errors++;
                    $display("FAIL commit_unexpected robid=%0d with empty order queue", bus.commit_robid);
                end else begin
                    e = alloc_q.pop_front();
                    if (bus.commit_robid !== e || bus.commit_value !== exp_val[e] ||
                        bus.commit_wbs !== exp_wbs[e] || bus.commit_flags !== exp_flg[e]) begin
                        errors++;
                        $display("FAIL commit_payload got id=%0d v=%h w=%h f=%h want id=%0d v=%h w=%h f=%h",
                                 bus.commit_robid, bus.commit_value, bus.commit_wbs, bus.commit_flags,
                                 e, exp_val[e], exp_wbs[e], exp_flg[e]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic do_alloc(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++;
            if (alloc_gnt !== 1'b1 || alloc_robid !== 8'(tb_tail)) begin
                errors++;
                $display("FAIL alloc got gnt=%0b robid=%0d want gnt=1 robid=%0d",
                         alloc_gnt, alloc_robid, tb_tail);
            end
            alloc_q.push_back(8'(tb_tail));
            tb_tail = (tb_tail + 1) % DEPTH;
            cyc();
        end
        alloc_req = 1'b0;
    endtask

    task automatic do_complete(input logic [7:0] id, input logic [7:0] fl,
                               input logic [7:0] wb, input logic [7:0] va,
                               input logic exp_acc);
        bus.fu_valid = 1'b1;
        bus.fu_robid = id;
        bus.fu_flags = fl;
        bus.fu_wbs   = wb;
        bus.fu_value = va;
        #1;
        checks++;
        if (bus.fu_accept !== exp_acc) begin
            errors++;
            $display("FAIL fu_accept robid=%0d got=%0b want=%0b", id, bus.fu_accept, exp_acc);
        end
        if (exp_acc) begin
            exp_val[id] = va;
            exp_wbs[id] = wb;
            exp_flg[id] = fl;
        end
        cyc();
        bus.fu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alloc_req = 1'b0;
        flush = 1'b0;
        bus.fu_valid = 1'b0;
        bus.fu_robid = '0;
        bus.fu_flags = '0;
        bus.fu_wbs = '0;
        bus.fu_value = '0;
        bus.commit_ready = 1'b0;
        alloc_q.delete();
        tb_tail = 0;
        #2;
        chk("reset_count", int'(count), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_alloc_gnt", int'(alloc_gnt), 0);
        chk("reset_commit_valid", int'(bus.commit_valid), 0);
        chk("reset_commit_payload", int'({bus.commit_robid, bus.commit_value, bus.commit_wbs, bus.commit_flags}), 0);
        chk("reset_fu_accept", int'(bus.fu_accept), 0);
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_in_order();
        test_reset();
        do_alloc(3);
        chk("io_count3", int'(count), 3);
        do_complete(8'd1, 8'h21, 8'h07, 8'hC3, 1'b1);
        chk("io_no_commit_head_pending", int'(bus.commit_valid), 0);
        bus.commit_ready = 1'b1;
        // No bypass: head completing this cycle is not yet committable.
        bus.fu_valid = 1'b1;
        bus.fu_robid = 8'd0;
        bus.fu_flags = 8'h11;
        bus.fu_wbs   = 8'h03;
        bus.fu_value = 8'h5A;
        #1;
        chk("io_accept0", int'(bus.fu_accept), 1);
        chk("io_no_bypass", int'(bus.commit_valid), 0);
        exp_val[0] = 8'h5A; exp_wbs[0] = 8'h03; exp_flg[0] = 8'h11;
        cyc();
        bus.fu_valid = 1'b0;
        chk("io_commit0_robid", int'(bus.commit_robid), 0);
        chk("io_commit0_value", int'(bus.commit_value), 'h5A);
        cyc();
        chk("io_commit1_robid", int'(bus.commit_robid), 1);
        chk("io_commit1_valid", int'(bus.commit_valid), 1);
        cyc();
        chk("io_robid2_held", int'(bus.commit_valid), 0);
        chk("io_count1", int'(count), 1);
        bus.commit_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        test_reset();
        do_alloc(DEPTH);
        chk("fw_full", int'(full), 1);
        chk("fw_count", int'(count), DEPTH);
        alloc_req = 1'b1;
        #1;
        chk("fw_refuse", int'(alloc_gnt), 0);
        cyc();
        alloc_req = 1'b0;
        chk("fw_count_held", int'(count), DEPTH);
        do_complete(8'd0, 8'h01, 8'h02, 8'h99, 1'b1);
        // Commit fires while full: allocation is still refused this cycle.
        bus.commit_ready = 1'b1;
        alloc_req = 1'b1;
        #1;
        chk("fw_full_commit_valid", int'(bus.commit_valid), 1);
        chk("fw_full_refuse_on_commit", int'(alloc_gnt), 0);
        cyc();
        bus.commit_ready = 1'b0;
        alloc_req = 1'b0;
        chk("fw_count15", int'(count), DEPTH - 1);
        chk("fw_not_full", int'(full), 0);
        do_alloc(1);
        chk("fw_full_again", int'(full), 1);
    endtask

    task automatic test_reject_stall();
        test_reset();
        do_alloc(2);
        do_complete(8'd0, 8'h44, 8'h05, 8'h77, 1'b1);
        do_complete(8'h20, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        do_complete(8'h11, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        do_complete(8'd5, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        do_complete(8'd0, 8'hFF, 8'hFF, 8'hEE, 1'b0);
        chk("rj_count", int'(count), 2);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", int'(bus.commit_valid), 1);
            chk("stall_value", int'(bus.commit_value), 'h77);
            chk("stall_flags", int'(bus.commit_flags), 'h44);
            cyc();
        end
        // Alloc and commit fire together.
        bus.commit_ready = 1'b1;
        alloc_req = 1'b1;
        #1;
        chk("bb_gnt", int'(alloc_gnt), 1);
        chk("bb_robid", int'(alloc_robid), 2);
        alloc_q.push_back(8'd2);
        tb_tail = 3;
        cyc();
        alloc_req = 1'b0;
        bus.commit_ready = 1'b0;
        chk("bb_count_same", int'(count), 2);
        chk("rj_no_alias_done", int'(bus.commit_valid), 0);
        do_complete(8'd2, 8'h0A, 8'h0B, 8'h0C, 1'b1);
        do_complete(8'd1, 8'h1A, 8'h1B, 8'h1C, 1'b1);
        bus.commit_ready = 1'b1;
        cyc();
        cyc();
        bus.commit_ready = 1'b0;
        chk("drain_count", int'(count), 0);
        chk("drain_valid", int'(bus.commit_valid), 0);
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        test_reset();
        do_alloc(5);
        do_complete(8'd1, 8'h01, 8'h01, 8'h01, 1'b1);
        do_complete(8'd2, 8'h02, 8'h02, 8'h02, 1'b1);
        flush = 1'b1;
        alloc_req = 1'b1;
        #1;
        chk("fl_gnt_blocked", int'(alloc_gnt), 0);
        cyc();
        flush = 1'b0;
        alloc_q.delete();
        tb_tail = 0;
        #1;
        chk("fl_count", int'(count), 0);
        chk("fl_commit_valid", int'(bus.commit_valid), 0);
        chk("fl_robid0", int'(alloc_robid), 0);
        alloc_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_reject_stall();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
